// File: rtl/dnn_pkg.sv
// Shared widths, default load size and FSM state type for the DNN parameter loader.
package dnn_pkg;

    localparam int WORD_W    = 5;
    localparam int RES_W     = 17;
    localparam int NUM_WORDS = 28;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        FIRE  = 3'd1,
        WAIT  = 3'd2,
        SEND0 = 3'd3,
        SEND1 = 3'd4
    } state_t;

endpackage

// File: rtl/dnn_loader_regfile.sv
// Parameter store: NUM_WORDS words of WORD_W bits, one indexed write port, all words visible on a flat bus.
module dnn_loader_regfile #(
    parameter int NUM_WORDS = dnn_pkg::NUM_WORDS,
    parameter int WORD_W    = dnn_pkg::WORD_W,
    parameter int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [WORD_W-1:0]           wdata,
    output logic [NUM_WORDS*WORD_W-1:0] rdata
);

    // Every word is read in parallel, so the store is a bank of registers rather than a RAM.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
            logic [WORD_W-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (we && (waddr == ADDR_W'(gi))) begin
                    slot_reg <= wdata;
                end
            end

            assign rdata[gi*WORD_W +: WORD_W] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/dnn_loader.sv
// Loads NUM_WORDS parameters, fires the network once and streams its two results (out0 then out1).
// Optional result-wait timeout is enabled by defining DNN_LOADER_TIMEOUT_EN.
module dnn_loader #(
    parameter int NUM_WORDS = dnn_pkg::NUM_WORDS,
    parameter int TMO_CYC   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic signed [dnn_pkg::WORD_W-1:0]    s_data,
    output logic [NUM_WORDS*dnn_pkg::WORD_W-1:0] prm_o,
    output logic                                 in_ready_o,
    input  logic [dnn_pkg::RES_W-1:0]            out0_i,
    input  logic [dnn_pkg::RES_W-1:0]            out1_i,
    input  logic                                 out0_ready_i,
    input  logic                                 out1_ready_i,
    output logic                                 r_valid,
    input  logic                                 r_ready,
    output logic [dnn_pkg::RES_W-1:0]            r_data,
    output logic                                 r_err,
    output logic                                 busy
);
    import dnn_pkg::*;

    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    if (TMO_CYC < 1) begin : g_bad_tmo_cyc
        $error("dnn_loader: TMO_CYC must be at least 1");
    end

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [RES_W-1:0]   cap0_reg;
    logic [RES_W-1:0]   cap1_reg;
    logic               got0_reg;
    logic               got1_reg;
    logic               in_ready_reg;
    logic               r_valid_reg;
    logic [RES_W-1:0]   r_data_reg;

    logic accept;
    logic last_word;
    logic both_done;

    assign s_ready    = (state_reg == LOAD);
    assign busy       = (state_reg != LOAD);
    assign accept     = s_valid && s_ready;
    assign last_word  = (cnt_reg == CNT_W'(NUM_WORDS - 1));
    // A flag arriving this cycle counts as captured, giving the 2-cycle fire-to-result minimum.
    assign both_done  = (got0_reg || out0_ready_i) && (got1_reg || out1_ready_i);

    assign in_ready_o = in_ready_reg;
    assign r_valid    = r_valid_reg;
    assign r_data     = r_data_reg;

`ifdef DNN_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             r_err_reg;
    assign r_err = r_err_reg;
`else
    assign r_err = 1'b0;
`endif

    dnn_loader_regfile #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W),
        .ADDR_W    (CNT_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .waddr (cnt_reg),
        .wdata (s_data),
        .rdata (prm_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= LOAD;
            cnt_reg      <= '0;
            cap0_reg     <= '0;
            cap1_reg     <= '0;
            got0_reg     <= 1'b0;
            got1_reg     <= 1'b0;
            in_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_data_reg   <= '0;
`ifdef DNN_LOADER_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
            r_err_reg    <= 1'b0;
`endif
        end else begin
            in_ready_reg <= 1'b0;
`ifdef DNN_LOADER_TIMEOUT_EN
            r_err_reg    <= 1'b0;
`endif
            case (state_reg)
                LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            cnt_reg      <= '0;
                            state_reg    <= FIRE;
                            in_ready_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    // Flags seen during the fire cycle belong to no request and are dropped.
                    got0_reg  <= 1'b0;
                    got1_reg  <= 1'b0;
                    state_reg <= WAIT;
`ifdef DNN_LOADER_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                end
                WAIT: begin
                    if (out0_ready_i) begin
                        cap0_reg <= out0_i;
                        got0_reg <= 1'b1;
                    end
                    if (out1_ready_i) begin
                        cap1_reg <= out1_i;
                        got1_reg <= 1'b1;
                    end
                    if (both_done) begin
                        state_reg   <= SEND0;
                        r_valid_reg <= 1'b1;
                        r_data_reg  <= out0_ready_i ? out0_i : cap0_reg;
                    end
`ifdef DNN_LOADER_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_W'(TMO_CYC - 1)) begin
                        r_err_reg <= 1'b1;
                        state_reg <= LOAD;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
`endif
                end
                SEND0: begin
                    if (r_ready) begin
                        state_reg  <= SEND1;
                        r_data_reg <= cap1_reg;
                    end
                end
                SEND1: begin
                    if (r_ready) begin
                        state_reg   <= LOAD;
                        r_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= LOAD;
                    r_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_loader.sv
// Directed bench for dnn_loader: load/fire, result ordering and hold, resets, and result-wait behaviour.
module tb_dnn_loader;

    localparam int NW  = 28;
    localparam int TMO = 16;
    localparam int PW  = NW * 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic signed [4:0]  s_data;
    logic [PW-1:0]      prm_o;
    logic               in_ready_o;
    logic [16:0]        out0_i;
    logic [16:0]        out1_i;
    logic               out0_ready_i;
    logic               out1_ready_i;
    logic               r_valid;
    logic               r_ready;
    logic [16:0]        r_data;
    logic               r_err;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    logic [PW-1:0] exp_prm;

    dnn_loader #(.NUM_WORDS(NW), .TMO_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .prm_o        (prm_o),
        .in_ready_o   (in_ready_o),
        .out0_i       (out0_i),
        .out1_i       (out1_i),
        .out0_ready_i (out0_ready_i),
        .out1_ready_i (out1_ready_i),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_data       (r_data),
        .r_err        (r_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (in_ready_o === 1'b1) fire_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: value (k mod 16)-8; mode 1: value (3k+1) mod 32. Returns right after the last accept edge.
    task automatic load_words(input int mode, input int gaps);
        logic [4:0] v;
        exp_prm = '0;
        for (int k = 0; k < NW; k++) begin
            v = (mode == 0) ? 5'((k % 16) - 8) : 5'((3 * k + 1) % 32);
            exp_prm[5*k +: 5] = v;
            s_valid = 1'b1;
            s_data  = v;
            tick();
            if (gaps != 0 && k != NW - 1) begin
                s_valid = 1'b0;
                s_data  = 5'h15;
                for (int g = 0; g <= k % 5; g++) tick();
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
        out0_i = '0; out1_i = '0; out0_ready_i = 1'b0; out1_ready_i = 1'b0;
        tick(); tick();
        chk("rst_busy", PW'(busy), PW'(1'b0));
        chk("rst_in_ready", PW'(in_ready_o), PW'(1'b0));
        chk("rst_r_valid", PW'(r_valid), PW'(1'b0));
        chk("rst_r_data", PW'(r_data), PW'(17'd0));
        chk("rst_r_err", PW'(r_err), PW'(1'b0));
        chk("rst_prm", prm_o, '0);
        rst = 1'b0;
        tick();
        chk("idle_s_ready", PW'(s_ready), PW'(1'b1));

        // Basic load with s_valid held high, 1-cycle network
        load_words(0, 0);
        chk("a_fire", PW'(in_ready_o), PW'(1'b1));
        chk("a_s_ready_fire", PW'(s_ready), PW'(1'b0));
        chk("a_prm", prm_o, exp_prm);
        chk("a_prm_w0", PW'(prm_o[4:0]), PW'(5'h18));
        chk("a_prm_w27", PW'(prm_o[139:135]), PW'(5'h03));
        tick();
        chk("a_fire_pulse_end", PW'(in_ready_o), PW'(1'b0));
        out0_i = 17'd100; out1_i = 17'h1FFFB; out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        chk("a_no_valid_yet", PW'(r_valid), PW'(1'b0));
        tick();
        out0_ready_i = 1'b0; out1_ready_i = 1'b0;
        chk("a_valid_lat2", PW'(r_valid), PW'(1'b1));
        chk("a_data0", PW'(r_data), PW'(17'd100));
        r_ready = 1'b1;
        tick();
        chk("a_valid1", PW'(r_valid), PW'(1'b1));
        chk("a_data1", PW'(r_data), PW'(17'h1FFFB));
        tick();
        r_ready = 1'b0;
        chk("a_done_valid", PW'(r_valid), PW'(1'b0));
        chk("a_done_s_ready", PW'(s_ready), PW'(1'b1));
        chk("a_fire_count", PW'(fire_cnt), PW'(1));

        // Flags during FIRE ignored; out1 3 cycles before out0; r_ready held low in SEND0
        load_words(0, 0);
        out0_i = 17'd555; out1_i = 17'd777; out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        tick();
        out0_ready_i = 1'b0; out1_ready_i = 1'b0;
        tick();
        chk("b_fire_flags_ignored", PW'(r_valid), PW'(1'b0));
        out1_i = 17'h0ABCD; out1_ready_i = 1'b1;
        tick();
        out1_ready_i = 1'b0; out1_i = 17'h00001;
        chk("b_out1_only", PW'(r_valid), PW'(1'b0));
        s_valid = 1'b1; s_data = 5'h0F;
        tick(); tick();
        out0_i = 17'h12345; out0_ready_i = 1'b1;
        tick();
        out0_ready_i = 1'b0; out0_i = 17'h00002;
        chk("b_valid", PW'(r_valid), PW'(1'b1));
        chk("b_data0", PW'(r_data), PW'(17'h12345));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_hold_data0", PW'(r_data), PW'(17'h12345));
        end
        chk("b_prm_stable_busy", prm_o, exp_prm);
        s_valid = 1'b0;
        r_ready = 1'b1;
        tick();
        chk("b_data1", PW'(r_data), PW'(17'h0ABCD));
        tick();
        r_ready = 1'b0;
        chk("b_done_valid", PW'(r_valid), PW'(1'b0));

        // Reset after word 10 (rst wins over a same-cycle accept), then gapped load
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_data = 5'h07;
            tick();
        end
        rst = 1'b1; s_data = 5'h09;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        chk("c_rst_prm", prm_o, '0);
        chk("c_rst_busy", PW'(busy), PW'(1'b0));
        begin
            int f0;
            f0 = fire_cnt;
            load_words(1, 1);
            chk("c_fire", PW'(in_ready_o), PW'(1'b1));
            chk("c_prm", prm_o, exp_prm);
            tick();
            chk("c_one_pulse", PW'(fire_cnt - f0), PW'(1));
        end
        out0_i = 17'd3; out1_i = 17'd4; out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        tick();
        out0_ready_i = 1'b0; out1_ready_i = 1'b0;
        chk("c_valid", PW'(r_valid), PW'(1'b1));
        rst = 1'b1; r_ready = 1'b1;
        tick();
        rst = 1'b0; r_ready = 1'b0;
        chk("c_rst_r_valid", PW'(r_valid), PW'(1'b0));
        chk("c_rst_r_data", PW'(r_data), PW'(17'd0));
        tick(); tick();
        chk("c_no_valid_after", PW'(r_valid), PW'(1'b0));
        chk("c_idle", PW'(s_ready), PW'(1'b1));

        // No result flags at all
        load_words(0, 0);
        tick();
`ifdef DNN_LOADER_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("d_no_err_early", PW'(r_err), PW'(1'b0));
        end
        tick();
        chk("d_err_pulse", PW'(r_err), PW'(1'b1));
        chk("d_err_s_ready", PW'(s_ready), PW'(1'b1));
        chk("d_err_no_valid", PW'(r_valid), PW'(1'b0));
        tick();
        chk("d_err_one_cycle", PW'(r_err), PW'(1'b0));
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("d_busy_held", PW'(busy), PW'(1'b1));
            chk("d_no_err", PW'(r_err), PW'(1'b0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnn_loader.md
DNN_LOADER -- requirements
Module: dnn_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 28, meaning the number of 5-bit words per load (4 inputs + 24 weights).
REQ-002 SHALL have parameter TMO_CYC, default 16, meaning the result-wait timeout in cycles (used only with DNN_LOADER_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_valid, input, 1 bit: the load word is valid.
REQ-006 SHALL have port s_ready, output, 1 bit: the loader accepts a word.
REQ-007 SHALL have port s_data, input, 5 bits signed: the load word.
REQ-008 SHALL have port prm_o, output, 140 bits: word k at [5k+4:5k]; order x0..x3, w04..w07, w14..w17, w24..w27, w34..w37, w48, w49, w58, w59, w68, w69, w78, w79.
REQ-009 SHALL have port in_ready_o, output, 1 bit: one-cycle fire pulse to the network.
REQ-010 SHALL have ports out0_i and out1_i, input, 17 bits each: network results.
REQ-011 SHALL have ports out0_ready_i and out1_ready_i, input, 1 bit each: result-valid flags.
REQ-012 SHALL have port r_valid, output, 1 bit: the result word is valid.
REQ-013 SHALL have port r_ready, input, 1 bit: the sink accepts the result word.
REQ-014 SHALL have port r_data, output, 17 bits: the result word.
REQ-015 SHALL have port r_err, output, 1 bit: timeout error pulse.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than LOAD.

Function
REQ-017 SHALL implement FSM states LOAD, FIRE, WAIT, SEND0 and SEND1.
REQ-018 In LOAD: s_ready=1; on s_valid&s_ready, write s_data into slot cnt and increment cnt.
REQ-019 When the word at cnt=NUM_WORDS-1 is accepted, cnt SHALL wrap to 0 and the FSM SHALL go to FIRE on the next cycle.
REQ-020 In FIRE: in_ready_o=1 for exactly one cycle, then go to WAIT; s_ready=0 in every state except LOAD.
REQ-021 prm_o SHALL be held stable from FIRE until the next word is accepted in LOAD.
REQ-022 In WAIT, out0_i SHALL be captured on the cycle out0_ready_i=1 and out1_i on the cycle out1_ready_i=1, independently.
REQ-023 Simultaneous flags SHALL capture both in that cycle; a flag asserted during FIRE SHALL be ignored.
REQ-024 When both results are captured, go to SEND0; minimum fire-to-r_valid latency is 2 cycles.
REQ-025 In SEND0: r_valid=1 and r_data=out0; on r_ready, go to SEND1.
REQ-026 In SEND1: r_data=out1; on r_ready, go to LOAD.
REQ-027 r_data SHALL be held stable while r_valid=1 and r_ready=0.
REQ-028 Results SHALL be passed through unmodified, with no sign extension or saturation.

Reset
REQ-029 On rst=1: state=LOAD, cnt=0, prm_o=0, capture registers=0, in_ready_o=0, r_valid=0, r_data=0, r_err=0, busy=0.
REQ-030 Reset mid-load or mid-transfer SHALL discard the partial load or results; no in_ready_o pulse and no r_valid SHALL follow.
REQ-031 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-032 With DNN_LOADER_TIMEOUT_EN defined: a WAIT counter SHALL clear on entry to WAIT.
REQ-033 With DNN_LOADER_TIMEOUT_EN defined: if both results are not captured after TMO_CYC WAIT cycles, r_err SHALL pulse 1 cycle and the FSM SHALL return to LOAD without sending results.
REQ-034 With DNN_LOADER_TIMEOUT_EN undefined: no counter; WAIT is unbounded; r_err SHALL be tied 0.

Structure
REQ-035 Package dnn_pkg SHALL hold WORD_W=5, RES_W=17, NUM_WORDS=28 and the FSM state enum type.
REQ-036 One sub-module, dnn_loader_regfile (NUM_WORDS x WORD_W indexed write, flat read), SHALL hold the parameter store; FSM and result path remain in dnn_loader.

Verification
REQ-037 Load 28 words k=0..27 with value (k mod 16)-8 and s_valid held high -> in_ready_o pulses 1 cycle after the 28th accept; prm_o word 0 = -8, word 27 = 3.
REQ-038 Model the network with 1-cycle latency, out0=100, out1=-5 (17-bit) -> r_data 100 then 0x1FFFB; r_valid asserted 2 cycles after in_ready_o.
REQ-039 out1_ready_i 3 cycles before out0_ready_i; r_ready low 4 cycles in SEND0 -> r_data=out0 held stable; order out0, out1.
REQ-040 rst asserted after word 10 -> next 28 words alone produce exactly one in_ready_o pulse; s_valid gaps of 1-5 cycles do not change that result.
REQ-041 With DNN_LOADER_TIMEOUT_EN, no ready flags -> r_err=1 exactly TMO_CYC cycles after WAIT entry, then s_ready=1; without the macro, busy stays 1 for 100 cycles.
